// File: rtl/ysyx_24090003_lsu_pkg.sv
// Shared encodings for the LSU: funct3 access sizes, FSM states, byte-strobe constants,
// and the alignment rule used to reject an access before it reaches the bus.
package ysyx_24090003_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_REQ_ENC  = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = ST_IDLE_ENC,
        ST_REQ      = ST_REQ_ENC,
        ST_WAIT_RSP = ST_WAIT_ENC,
        ST_DONE     = ST_DONE_ENC
    } state_e;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_B    = 4'b0001;
    localparam logic [3:0] STRB_H    = 4'b0011;
    localparam logic [3:0] STRB_W    = 4'b1111;

    // Unknown funct3 codes fall into the word case, so they need full word alignment.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        case (f3)
            F3_B, F3_BU: mis = 1'b0;
            F3_H, F3_HU: mis = lo[0];
            default:     mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_24090003_lsu_if.sv
// Execute/write-back handshake plus the word bus of the LSU, bundled as one port.
// slave is the LSU side; master is the surrounding pipeline and memory.
interface ysyx_24090003_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              i_valid;
    logic              o_ready;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_wdata;
    logic              i_mem_ren;
    logic              i_mem_wen;
    logic [2:0]        i_funct3;
    logic              o_valid;
    logic              i_ready;
    logic [31:0]       o_mem_rdata;
    logic              o_fault;
    logic              o_misaligned;
    logic              o_req_valid;
    logic              i_req_ready;
    logic              o_req_we;
    logic [ADDR_W-1:0] o_req_addr;
    logic [31:0]       o_req_wdata;
    logic [3:0]        o_req_wstrb;
    logic              i_rsp_valid;
    logic              o_rsp_ready;
    logic [31:0]       i_rsp_rdata;
    logic              i_rsp_err;

    modport slave (
        input  i_valid, i_addr, i_wdata, i_mem_ren, i_mem_wen, i_funct3, i_ready,
        input  i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err,
        output o_ready, o_valid, o_mem_rdata, o_fault, o_misaligned,
        output o_req_valid, o_req_we, o_req_addr, o_req_wdata, o_req_wstrb, o_rsp_ready
    );

    modport master (
        output i_valid, i_addr, i_wdata, i_mem_ren, i_mem_wen, i_funct3, i_ready,
        output i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err,
        input  o_ready, o_valid, o_mem_rdata, o_fault, o_misaligned,
        input  o_req_valid, o_req_we, o_req_addr, o_req_wdata, o_req_wstrb, o_rsp_ready
    );
endinterface

// File: rtl/ysyx_24090003_lsu_align.sv
// Byte-lane steering: store strobe/replication and load byte-select with sign/zero extension.
// Purely combinational, no backpressure.
module ysyx_24090003_lsu_align
    import ysyx_24090003_lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] lane_sh;

    // Move the addressed lane down to bit 0; word accesses are aligned so this is a no-op for them.
    assign lane_sh = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        wstrb_o = STRB_W;
        wdata_o = wdata_i;
        rdata_o = lane_sh;
        case (funct3_i)
            F3_B, F3_BU: begin
                wstrb_o = STRB_B << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{lane_sh[7] & ~funct3_i[2]}}, lane_sh[7:0]};
            end
            F3_H, F3_HU: begin
                wstrb_o = STRB_H << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{lane_sh[15] & ~funct3_i[2]}}, lane_sh[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_24090003_lsu.sv
// Load/store unit: one word-aligned bus transaction per memory op, extended load data to write-back.
// Latency 1 cycle for non-memory/misaligned ops, 3+ for bus ops; accepts only in IDLE, holds result until i_ready.
module ysyx_24090003_lsu
    import ysyx_24090003_lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RSP_TIMEOUT = 255
) (
    input logic                i_clk,
    input logic                i_rst_n,
    ysyx_24090003_lsu_if.slave bus
);

    localparam int CNT_W = $clog2(RSP_TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((RSP_TIMEOUT > 0) ? RSP_TIMEOUT - 1 : 0);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        funct3_q;
    logic              ren_q;
    logic              wen_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              fault_q;
    logic              mis_q;
    logic              ready_q;
    logic              valid_q;
    logic              req_valid_q;
    logic              rsp_ready_q;

    logic [3:0]        wstrb;
    logic [31:0]       wdata_rep;
    logic [DATA_W-1:0] rdata_d;

    ysyx_24090003_lsu_align u_align (
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (bus.i_rsp_rdata),
        .wstrb_o   (wstrb),
        .wdata_o   (wdata_rep),
        .rdata_o   (rdata_d)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
            mis_q       <= 1'b0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            req_valid_q <= 1'b0;
            rsp_ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_valid) begin
                        addr_q   <= bus.i_addr;
                        wdata_q  <= bus.i_wdata;
                        funct3_q <= bus.i_funct3;
                        ren_q    <= bus.i_mem_ren;
                        wen_q    <= bus.i_mem_wen;
                        rdata_q  <= '0;
                        ready_q  <= 1'b0;
                        if (!(bus.i_mem_ren || bus.i_mem_wen)) begin
                            valid_q <= 1'b1;
                            state_q <= ST_DONE;
                        end else if (is_misaligned(bus.i_funct3, bus.i_addr[1:0])) begin
                            mis_q   <= 1'b1;
                            valid_q <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            req_valid_q <= 1'b1;
                            state_q     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.i_req_ready) begin
                        req_valid_q <= 1'b0;
                        rsp_ready_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    // A response in the final timeout cycle wins over the timeout.
                    if (bus.i_rsp_valid) begin
                        if (ren_q) rdata_q <= rdata_d;
                        fault_q     <= bus.i_rsp_err;
                        rsp_ready_q <= 1'b0;
                        valid_q     <= 1'b1;
                        state_q     <= ST_DONE;
                    end else if (RSP_TIMEOUT != 0 && cnt_q == TO_LAST) begin
                        fault_q     <= 1'b1;
                        rsp_ready_q <= 1'b0;
                        valid_q     <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        fault_q <= 1'b0;
                        mis_q   <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_ready      = ready_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_mem_rdata  = rdata_q;
    assign bus.o_fault      = fault_q;
    assign bus.o_misaligned = mis_q;
    assign bus.o_req_valid  = req_valid_q;
    assign bus.o_req_we     = wen_q;
    assign bus.o_req_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.o_req_wdata  = wdata_rep;
    assign bus.o_req_wstrb  = wen_q ? wstrb : STRB_NONE;
    assign bus.o_rsp_ready  = rsp_ready_q;

endmodule

// File: tb/tb_ysyx_24090003_lsu.sv
// Bench for ysyx_24090003_lsu: vector table driven through a reactive bus model,
// expected results queued at issue and compared when write-back sees o_valid.
module tb_ysyx_24090003_lsu;
    import ysyx_24090003_lsu_pkg::*;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ysyx_24090003_lsu_if #(.ADDR_W(32)) bus ();

    ysyx_24090003_lsu #(.ADDR_W(32), .DATA_W(32), .RSP_TIMEOUT(TO)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [2:0]  f3;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rsp_rdata;
        logic        rsp_err;
        int          req_stall;
        int          rsp_delay;   // <0: bus never answers
        int          wb_stall;
        logic        exp_req;
        logic [31:0] exp_req_addr;
        logic [31:0] exp_req_wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        logic        exp_mis;
        int          exp_lat;
    } vec_t;

    vec_t sb_q[$];
    vec_t vecs[16];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_valid     = 1'b0;
        bus.i_addr      = '0;
        bus.i_wdata     = '0;
        bus.i_mem_ren   = 1'b0;
        bus.i_mem_wen   = 1'b0;
        bus.i_funct3    = '0;
        bus.i_ready     = 1'b0;
        bus.i_req_ready = 1'b0;
        bus.i_rsp_valid = 1'b0;
        bus.i_rsp_rdata = '0;
        bus.i_rsp_err   = 1'b0;
    endtask

    function automatic vec_t mk(input logic [2:0] f3, input logic ren, input logic wen,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rrd, input logic err,
                                input int rs, input int rd, input int ws,
                                input logic er, input logic [31:0] era, input logic [31:0] erw,
                                input logic [3:0] es, input logic [31:0] erd,
                                input logic ef, input logic em, input int lat);
        vec_t v;
        v.f3 = f3; v.ren = ren; v.wen = wen; v.addr = addr; v.wdata = wdata;
        v.rsp_rdata = rrd; v.rsp_err = err;
        v.req_stall = rs; v.rsp_delay = rd; v.wb_stall = ws;
        v.exp_req = er; v.exp_req_addr = era; v.exp_req_wdata = erw; v.exp_wstrb = es;
        v.exp_rdata = erd; v.exp_fault = ef; v.exp_mis = em; v.exp_lat = lat;
        return v;
    endfunction

    // Called right after a negedge with the DUT in IDLE; returns right after a negedge in IDLE.
    task automatic run_op(input int id, input vec_t v);
        vec_t e;
        int   req_st = 0, rwt = 0, wbs = 0, reqs = 0, rsps = 0, exp_rsps;
        bit   seen = 0, released = 0, fin = 0;
        bus.i_valid   = 1'b1;
        bus.i_addr    = v.addr;
        bus.i_wdata   = v.wdata;
        bus.i_mem_ren = v.ren;
        bus.i_mem_wen = v.wen;
        bus.i_funct3  = v.f3;
        sb_q.push_back(v);
        e = v;
        for (int c = 1; c <= 60 && !fin; c++) begin
            @(negedge clk);
            idle_inputs();
            if (released) begin
                chk($sformatf("op%0d_back_ready", id), bus.o_ready, 1);
                chk($sformatf("op%0d_back_valid", id), bus.o_valid, 0);
                chk($sformatf("op%0d_fault_clr", id), bus.o_fault, 0);
                chk($sformatf("op%0d_mis_clr", id), bus.o_misaligned, 0);
                fin = 1;
            end else begin
                if (bus.o_req_valid) begin
                    reqs++;
                    if (v.exp_req) begin
                        chk($sformatf("op%0d_req_addr", id), bus.o_req_addr, v.exp_req_addr);
                        chk($sformatf("op%0d_req_we", id), bus.o_req_we, v.wen);
                        chk($sformatf("op%0d_req_wdata", id), bus.o_req_wdata, v.exp_req_wdata);
                        chk($sformatf("op%0d_req_wstrb", id), bus.o_req_wstrb, v.exp_wstrb);
                    end
                    if (req_st == v.req_stall) bus.i_req_ready = 1'b1;
                    else req_st++;
                end
                if (bus.o_rsp_ready) begin
                    rsps++;
                    if (v.rsp_delay >= 0) begin
                        if (rwt == v.rsp_delay) begin
                            bus.i_rsp_valid = 1'b1;
                            bus.i_rsp_rdata = v.rsp_rdata;
                            bus.i_rsp_err   = v.rsp_err;
                        end else rwt++;
                    end
                end
                if (bus.o_valid) begin
                    if (!seen) begin
                        seen = 1;
                        chk($sformatf("op%0d_sb_nonempty", id), sb_q.size() != 0, 1);
                        if (sb_q.size() != 0) e = sb_q.pop_front();
                        chk($sformatf("op%0d_latency", id), c, e.exp_lat);
                    end
                    chk($sformatf("op%0d_rdata", id), bus.o_mem_rdata, e.exp_rdata);
                    chk($sformatf("op%0d_fault", id), bus.o_fault, e.exp_fault);
                    chk($sformatf("op%0d_misaligned", id), bus.o_misaligned, e.exp_mis);
                    chk($sformatf("op%0d_ready_low", id), bus.o_ready, 0);
                    if (wbs == v.wb_stall) begin
                        bus.i_ready = 1'b1;
                        released = 1;
                    end else wbs++;
                end
            end
        end
        if (!fin) begin
            n_chk++;
            n_err++;
            $display("FAIL op%0d_complete: no completion within 60 cycles, expected write-back handshake", id);
        end
        exp_rsps = !v.exp_req ? 0 : (v.rsp_delay < 0 ? TO : v.rsp_delay + 1);
        chk($sformatf("op%0d_req_issued", id), reqs != 0, v.exp_req);
        chk($sformatf("op%0d_rsp_cycles", id), rsps, exp_rsps);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", bus.o_ready, 1);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_req_valid", bus.o_req_valid, 0);
        chk("rst_rsp_ready", bus.o_rsp_ready, 0);
        chk("rst_fault", bus.o_fault, 0);
        chk("rst_misaligned", bus.o_misaligned, 0);
        chk("rst_rdata", bus.o_mem_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0]  = mk(F3_B, 0, 0, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 0,
                      0, 32'h0, 32'h0, 4'b0000, 32'h0, 0, 0, 1);
        vecs[1]  = mk(F3_B, 1, 0, 32'h8000_0003, 32'h1122_3344, 32'h80FF_1234, 0, 0, 0, 0,
                      1, 32'h8000_0000, 32'h4444_4444, 4'b0000, 32'hFFFF_FF80, 0, 0, 3);
        vecs[2]  = mk(F3_BU, 1, 0, 32'h8000_0003, 32'h1122_3344, 32'h80FF_1234, 0, 0, 0, 1,
                      1, 32'h8000_0000, 32'h4444_4444, 4'b0000, 32'h0000_0080, 0, 0, 3);
        vecs[3]  = mk(F3_H, 0, 1, 32'h8000_0002, 32'h0000_ABCD, 32'hFFFF_FFFF, 0, 0, 0, 0,
                      1, 32'h8000_0000, 32'hABCD_ABCD, 4'b1100, 32'h0, 0, 0, 3);
        vecs[4]  = mk(F3_W, 1, 0, 32'h8000_0002, 32'h0, 32'h0, 0, 0, 0, 0,
                      0, 32'h0, 32'h0, 4'b0000, 32'h0, 0, 1, 1);
        vecs[5]  = mk(F3_H, 1, 0, 32'h8000_0002, 32'h0, 32'h8001_7FFF, 0, 0, 0, 0,
                      1, 32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_8001, 0, 0, 3);
        vecs[6]  = mk(F3_HU, 1, 0, 32'h8000_0000, 32'h0, 32'h8001_F00F, 0, 0, 2, 0,
                      1, 32'h8000_0000, 32'h0, 4'b0000, 32'h0000_F00F, 0, 0, 5);
        vecs[7]  = mk(F3_B, 0, 1, 32'h8000_0001, 32'h0000_00A5, 32'h0, 0, 1, 0, 0,
                      1, 32'h8000_0000, 32'hA5A5_A5A5, 4'b0010, 32'h0, 0, 0, 4);
        vecs[8]  = mk(F3_W, 0, 1, 32'h8000_0004, 32'hCAFE_BABE, 32'h0, 0, 0, 0, 0,
                      1, 32'h8000_0004, 32'hCAFE_BABE, 4'b1111, 32'h0, 0, 0, 3);
        vecs[9]  = mk(F3_H, 1, 0, 32'h8000_0001, 32'h0, 32'h0, 0, 0, 0, 0,
                      0, 32'h0, 32'h0, 4'b0000, 32'h0, 0, 1, 1);
        vecs[10] = mk(F3_W, 1, 0, 32'h8000_0010, 32'h0, 32'h1234_5678, 1, 5, 1, 3,
                      1, 32'h8000_0010, 32'h0, 4'b0000, 32'h1234_5678, 1, 0, 9);
        vecs[11] = mk(F3_W, 1, 0, 32'h8000_0020, 32'h0, 32'h0, 0, 0, -1, 0,
                      1, 32'h8000_0020, 32'h0, 4'b0000, 32'h0, 1, 0, 2 + TO);
        vecs[12] = mk(3'b011, 1, 0, 32'h8000_0008, 32'h0102_0304, 32'h89AB_CDEF, 0, 0, 0, 0,
                      1, 32'h8000_0008, 32'h0102_0304, 4'b0000, 32'h89AB_CDEF, 0, 0, 3);
        vecs[13] = mk(3'b111, 1, 0, 32'h8000_0009, 32'h0, 32'h0, 0, 0, 0, 0,
                      0, 32'h0, 32'h0, 4'b0000, 32'h0, 0, 1, 1);
        vecs[14] = mk(F3_BU, 1, 0, 32'h8000_0006, 32'h0, 32'h00C3_0000, 0, 0, 0, 0,
                      1, 32'h8000_0004, 32'h0, 4'b0000, 32'h0000_00C3, 0, 0, 3);
        vecs[15] = mk(F3_W, 0, 1, 32'h8000_0003, 32'h5555_5555, 32'h0, 0, 0, 0, 0,
                      0, 32'h0, 32'h0, 4'b0000, 32'h0, 0, 1, 1);

        for (int i = 0; i < 16; i++) run_op(i, vecs[i]);

        // A stray response while IDLE must be ignored.
        for (int k = 0; k < 2; k++) begin
            bus.i_rsp_valid = 1'b1;
            bus.i_rsp_err   = 1'b1;
            bus.i_rsp_rdata = 32'hFFFF_FFFF;
            @(negedge clk);
            chk($sformatf("late_rsp%0d_valid", k), bus.o_valid, 0);
            chk($sformatf("late_rsp%0d_fault", k), bus.o_fault, 0);
            chk($sformatf("late_rsp%0d_ready", k), bus.o_ready, 1);
            chk($sformatf("late_rsp%0d_rsp_ready", k), bus.o_rsp_ready, 0);
        end
        idle_inputs();

        // Reset while waiting for a response.
        bus.i_valid   = 1'b1;
        bus.i_mem_ren = 1'b1;
        bus.i_funct3  = F3_W;
        bus.i_addr    = 32'h8000_0040;
        @(negedge clk);
        idle_inputs();
        chk("rstmid_req_valid", bus.o_req_valid, 1);
        bus.i_req_ready = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("rstmid_rsp_ready", bus.o_rsp_ready, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_ready", bus.o_ready, 1);
        chk("rstmid_valid", bus.o_valid, 0);
        chk("rstmid_rsp_ready_clr", bus.o_rsp_ready, 0);
        chk("rstmid_req_valid_clr", bus.o_req_valid, 0);
        chk("rstmid_fault", bus.o_fault, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(100, vecs[1]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ysyx_24090003_lsu.md
Name: ysyx_24090003_lsu

Overview:
Load/store unit between the execute stage and the write-back unit of the multicycle core. It takes one memory-op request per instruction over a valid/ready handshake and issues one word-aligned bus transaction. It returns load data, already byte-selected and sign/zero-extended, to write-back as the memory read-data input. Non-memory instructions pass through with one cycle of latency.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; only 32 is supported
RSP_TIMEOUT, 255, cycles to wait for a bus response before faulting; 0 disables the timeout

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous reset, active-low
i_valid  in  1  upstream instruction valid
o_ready  out  1  LSU can accept; high only in IDLE
i_addr  in  ADDR_W  effective address (ALU result)
i_wdata  in  32  store data (rs2)
i_mem_ren  in  1  load instruction
i_mem_wen  in  1  store instruction; i_mem_ren and i_mem_wen both high is illegal
i_funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
o_valid  out  1  result valid to write-back
i_ready  in  1  write-back accepts
o_mem_rdata  out  32  extended load data; 0 for stores and non-memory instructions
o_fault  out  1  bus error or timeout
o_misaligned  out  1  h/hu/w address not naturally aligned
o_req_valid  out  1  bus request valid
i_req_ready  in  1  bus accepts request
o_req_we  out  1  1 = write
o_req_addr  out  ADDR_W  address with bits [1:0] forced to 00
o_req_wdata  out  32  store data replicated into lanes (byte x4, half x2)
o_req_wstrb  out  4  byte enables; 0000 on reads
i_rsp_valid  in  1  bus response valid
o_rsp_ready  out  1  high only in WAIT_RSP
i_rsp_rdata  in  32  read word
i_rsp_err  in  1  response error

Behaviour:
- Reset: state IDLE; o_ready=1; o_valid, o_req_valid, o_rsp_ready, o_fault, o_misaligned = 0; o_mem_rdata=0; timeout counter=0.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE: on i_valid&o_ready, latch addr, wdata, funct3, ren, wen.
  - Non-memory instruction -> DONE.
  - Misaligned (h: addr[0]; w: addr[1:0]!=0) -> DONE with o_misaligned=1; no bus transaction is issued.
  - Otherwise -> REQ.
- REQ: o_req_valid=1; request fields stay stable until i_req_ready. On handshake -> WAIT_RSP with counter cleared.
- WAIT_RSP: o_rsp_ready=1; counter increments each cycle.
  - On i_rsp_valid: register extended data for loads; o_fault=i_rsp_err -> DONE. Data is still registered when the error bit is set.
  - If RSP_TIMEOUT!=0 and counter reaches RSP_TIMEOUT-1 without a response: o_fault=1 -> DONE. A response in that same cycle takes priority over the timeout.
  - The FSM returns to IDLE after a timeout; a late response arriving there is dropped because o_rsp_ready=0.
- DONE: o_valid=1; outputs held until i_ready, then -> IDLE. o_fault and o_misaligned clear on that IDLE transition.
- Load extraction: lane=addr[1:0]. b/h sign-extend, bu/hu zero-extend, w passes through.
- Store strobe: b = 0001<<addr[1:0]; h = 0011<<addr[1:0]; w = 1111.
- Latency: non-memory or misaligned op gives o_valid 1 cycle after accept. Memory op with zero-wait bus: REQ 1 cycle + response 1 cycle, so o_valid 3 cycles after accept.
- Reset asserted mid-transaction: asynchronous return to IDLE with all outputs at reset values. The bus must be reset together with the LSU.
- Illegal funct3 on a memory op is treated as w.

Decomposition:
- Shared define file: funct3 encodings, FSM state encoding (2-bit localparams), strobe constants.
- One natural sub-module: ysyx_24090003_lsu_align. It is combinational and produces wstrb/wdata replication and load extraction/extension.

Test Plan:
- Non-memory op, i_valid=1 -> o_valid after 1 cycle, o_mem_rdata=0, no o_req_valid.
- lb at addr 0x80000003, rdata 0x80FF_1234 -> o_req_addr 0x80000000, o_mem_rdata 0xFFFFFF80. Same access as lbu -> 0x00000080.
- sh at addr 0x80000002, wdata 0x0000ABCD -> o_req_wstrb 1100, o_req_wdata 0xABCDABCD, o_req_we=1.
- lw at addr 0x80000002 -> o_misaligned=1 after 1 cycle, no bus request.
- i_req_ready held low 5 cycles, then rsp with i_rsp_err=1 -> request stable throughout, o_fault=1 in DONE; i_ready held low 3 cycles -> outputs stable.
- RSP_TIMEOUT=4, no response -> o_fault after exactly 4 WAIT_RSP cycles. Separately, reset asserted during WAIT_RSP -> o_ready=1, o_valid=0 immediately.
